// File: rtl/sqrt_pipe_vr_if.sv
// -----------------------------------------------------------------------------
// sqrt_pipe_vr_if
// Valid/ready bundle for the pipelined square-root block.
//   in_valid / in_ready / in_data / in_tag      : radicand beat into the block
//   out_valid / out_ready / out_data / out_tag  : root beat out of the block
// Modports:
//   master : the side that produces radicands and consumes roots
//   slave  : the square-root block itself
// -----------------------------------------------------------------------------
interface sqrt_pipe_vr_if #(
    parameter int IN_W  = 18,
    parameter int OUT_W = 15,
    parameter int TAG_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/sqrt_pipe_vr.sv
// -----------------------------------------------------------------------------
// sqrt_pipe_vr
// Fully pipelined fixed-point square root with valid/ready flow control.
// out_data = sqrt(in_data) with OUT_F fractional bits, either truncated
// (ROUND=0) or rounded half-up with saturation (ROUND=1). One result bit is
// resolved per pipeline stage by restoring digit recurrence; the whole pipe
// advances together or holds together, so ordering is strictly FIFO.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset, empties the pipe
//   bus    : sqrt_pipe_vr_if.slave (in_* radicand beat, out_* root beat)
// Parameters:
//   IN_W   : radicand width            OUT_F : fractional bits of the root
//   ROUND  : 0 floor, 1 round-to-nearest (saturating)
//   TAG_W  : sideband width, carried unmodified alongside each beat
// The interface instance must use OUT_W = (IN_W+1)/2 + OUT_F.
// -----------------------------------------------------------------------------
module sqrt_pipe_vr #(
    parameter int IN_W  = 18,
    parameter int OUT_F = 6,
    parameter int ROUND = 0,
    parameter int TAG_W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    sqrt_pipe_vr_if.slave bus
);
    localparam int OUT_W = (IN_W + 1) / 2 + OUT_F;
    // Rounding needs one extra root bit, resolved by one extra stage.
    localparam int LAT   = OUT_W + ROUND;
    localparam int RAD_W = 2 * LAT;
    localparam int REM_W = LAT + 2;
    localparam int SH    = 2 * OUT_F + 2 * ROUND;

    logic             adv_s;
    logic [RAD_W-1:0] rad0_s;

    logic [LAT-1:0]   vld_r;
    logic [RAD_W-1:0] rad_r  [LAT];
    logic [REM_W-1:0] rem_r  [LAT];
    logic [LAT-1:0]   root_r [LAT];
    logic [TAG_W-1:0] tag_r  [LAT];

    logic [RAD_W-1:0] rad_nxt_s  [LAT];
    logic [REM_W-1:0] rem_nxt_s  [LAT];
    logic [LAT-1:0]   root_nxt_s [LAT];

    // The pipe moves whenever the output slot is empty or being taken.
    assign adv_s         = ~vld_r[LAT-1] | bus.out_ready;
    assign bus.in_ready  = adv_s;
    assign bus.out_valid = vld_r[LAT-1];
    assign bus.out_data  = root_r[LAT-1][OUT_W-1:0];
    assign bus.out_tag   = tag_r[LAT-1];

    // Radicand scaled so the integer root carries the fractional bits.
    assign rad0_s = RAD_W'(bus.in_data) << SH;

    for (genvar s = 0; s < LAT; s++) begin : g_stage
        logic [RAD_W-1:0] rad_in_s;
        logic [REM_W-1:0] rem_in_s;
        logic [LAT-1:0]   root_in_s;
        logic [REM_W-1:0] rem_sh_s;
        logic [REM_W-1:0] trial_s;
        logic [REM_W-1:0] rem_o_s;
        logic             bit_s;
        logic [LAT-1:0]   root_bit_s;

        if (s == 0) begin : g_first
            assign rad_in_s  = rad0_s;
            assign rem_in_s  = {REM_W{1'b0}};
            assign root_in_s = {LAT{1'b0}};
        end else begin : g_next
            assign rad_in_s  = rad_r[s-1];
            assign rem_in_s  = rem_r[s-1];
            assign root_in_s = root_r[s-1];
        end

        // One digit: bring down the next radicand pair and try subtracting 4q+1.
        always_comb begin
            rem_sh_s = {rem_in_s[REM_W-3:0], rad_in_s[RAD_W-1 -: 2]};
            trial_s  = {root_in_s, 2'b01};
            rem_o_s  = rem_sh_s;
            bit_s    = 1'b0;
            if (rem_sh_s >= trial_s) begin
                rem_o_s = rem_sh_s - trial_s;
                bit_s   = 1'b1;
            end else begin
                rem_o_s = rem_sh_s;
                bit_s   = 1'b0;
            end
        end

        assign root_bit_s    = {root_in_s[LAT-2:0], bit_s};
        assign rem_nxt_s[s]  = rem_o_s;
        assign rad_nxt_s[s]  = {rad_in_s[RAD_W-3:0], 2'b00};

        if ((ROUND != 0) && (s == LAT - 1)) begin : g_round
            // Add half an output LSB, drop the guard bit, clamp on carry-out.
            logic [LAT:0] sum_s;
            assign sum_s = {1'b0, root_bit_s} + {{LAT{1'b0}}, 1'b1};
            assign root_nxt_s[s] = sum_s[LAT] ? {1'b0, {OUT_W{1'b1}}} : sum_s[LAT:1];
        end else begin : g_plain
            assign root_nxt_s[s] = root_bit_s;
        end
    end

    // Stage registers: reset empties the pipe, otherwise all shift or all hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_r <= {LAT{1'b0}};
            for (int s = 0; s < LAT; s++) begin
                rad_r[s]  <= {RAD_W{1'b0}};
                rem_r[s]  <= {REM_W{1'b0}};
                root_r[s] <= {LAT{1'b0}};
                tag_r[s]  <= {TAG_W{1'b0}};
            end
        end else if (adv_s) begin
            vld_r    <= {vld_r[LAT-2:0], bus.in_valid};
            tag_r[0] <= bus.in_tag;
            for (int s = 0; s < LAT; s++) begin
                rad_r[s]  <= rad_nxt_s[s];
                rem_r[s]  <= rem_nxt_s[s];
                root_r[s] <= root_nxt_s[s];
            end
            for (int s = 1; s < LAT; s++) begin
                tag_r[s] <= tag_r[s-1];
            end
        end else begin
            vld_r <= vld_r;
        end
    end
endmodule
